// File: rtl/sram_stage_sequencer.sv
// ---------------------------------------------------------------------------
// sram_stage_sequencer
//
// Decides who owns the single SRAM port of the image decompressor. After a
// start request from the pushbutton or UART line activity, the UART receiver
// loads the bitstream. The load ends once the UART has been idle long enough.
// The enabled decode stages then run one at a time, from the highest index
// down to the lowest. Finally the SRAM is handed back to the VGA display.
// A per-stage watchdog can stop a stage that hangs. The sequencer then waits
// in an error state until the pushbutton is pressed.
//
// Ports
//   CLOCK_50_I, resetn       : clock, asynchronous active-low reset
//   uart_rx_line, pb_start   : start requests (line low = activity)
//   stage_en_mask            : stages to run, latched when the load ends
//   uart_init, uart_enable   : one-cycle UART receiver control pulses
//   uart_addr/wdata/we_n     : UART-side SRAM request
//   stage_start              : one-hot, one-cycle start pulse per stage
//   stage_done               : per-stage done (level or pulse)
//   stage_addr/wdata/we_n    : flattened per-stage SRAM requests
//   vga_addr, vga_enable     : VGA read address, VGA display enable
//   sram_addr/wdata/we_n     : muxed request to the SRAM controller
//   seq_state, active_stage  : status: state code and current stage
//   err_stage, seq_error     : status: stage that timed out, sticky error
//   seq_done                 : one-cycle pulse when every stage has finished
// ---------------------------------------------------------------------------
module sram_stage_sequencer #(
  parameter int NUM_STAGES   = 3,
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 16,
  parameter int UART_TIMEOUT = 50_000_000,
  parameter int WD_CYCLES    = 0
) (
  input  logic                         CLOCK_50_I,
  input  logic                         resetn,
  input  logic                         uart_rx_line,
  input  logic                         pb_start,
  input  logic [NUM_STAGES-1:0]        stage_en_mask,
  output logic                         uart_init,
  output logic                         uart_enable,
  input  logic [ADDR_W-1:0]            uart_addr,
  input  logic [DATA_W-1:0]            uart_wdata,
  input  logic                         uart_we_n,
  output logic [NUM_STAGES-1:0]        stage_start,
  input  logic [NUM_STAGES-1:0]        stage_done,
  input  logic [NUM_STAGES*ADDR_W-1:0] stage_addr,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_wdata,
  input  logic [NUM_STAGES-1:0]        stage_we_n,
  input  logic [ADDR_W-1:0]            vga_addr,
  output logic                         vga_enable,
  output logic [ADDR_W-1:0]            sram_addr,
  output logic [DATA_W-1:0]            sram_wdata,
  output logic                         sram_we_n,
  output logic [2:0]                   seq_state,
  output logic [$clog2(NUM_STAGES):0]  active_stage,
  output logic [$clog2(NUM_STAGES):0]  err_stage,
  output logic                         seq_error,
  output logic                         seq_done
);

  localparam int IDX_W = $clog2(NUM_STAGES) + 1;
  localparam int UT_W  = $clog2(UART_TIMEOUT + 2);
  localparam int WD_W  = $clog2(WD_CYCLES + 2);

  localparam logic [UT_W-1:0] UT_LAST = UT_W'(UART_TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((WD_CYCLES > 0) ? (WD_CYCLES - 1) : 0);
  localparam logic [WD_W-1:0] WD_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_UART_EN     = 3'd1,
    S_UART_WAIT   = 3'd2,
    S_STAGE_START = 3'd3,
    S_STAGE_WAIT  = 3'd4,
    S_ERROR       = 3'd5
  } state_t;

  state_t                  state_q;
  logic [UT_W-1:0]         uartTimer_q;
  logic [WD_W-1:0]         wdTimer_q;
  logic [NUM_STAGES-1:0]   mask_q;
  logic [IDX_W-1:0]        activeStage_q;
  logic [IDX_W-1:0]        errStage_q;
  logic                    uartInit_q;
  logic                    uartEnable_q;
  logic [NUM_STAGES-1:0]   stageStart_q;
  logic                    vgaEnable_q;
  logic                    seqError_q;
  logic                    seqDone_q;

  logic                    hiFound;
  logic [IDX_W-1:0]        hiIdx;
  logic                    loFound;
  logic [IDX_W-1:0]        loIdx;
  logic                    activeDone;
  logic [NUM_STAGES-1:0]   activeOneHot;
  logic                    uartQuiet;
  logic                    loadEnd;
  logic                    wdExpired;

  // A cycle counts as UART idle only when there is no write and no receiver
  // initialise. The load ends when the idle run reaches the timeout. The UART
  // must also have moved off address 0, so an empty load never ends.
  assign uartQuiet = uart_we_n && !uartInit_q;
  assign loadEnd   = (state_q == S_UART_WAIT) && uartQuiet &&
                     (uartTimer_q == UT_LAST) && (uart_addr != '0);
  assign wdExpired = (WD_CYCLES != 0) && (wdTimer_q == WD_LAST);

  // Stage selection. Only loop indices below NUM_STAGES can be produced
  // here, so active_stage can never address a stage that does not exist.
  // hiIdx is the first stage to run, taken from the live mask at load end.
  // loIdx is the next enabled stage below the active one, taken from the
  // mask latched at load end.
  always_comb begin
    hiFound      = 1'b0;
    hiIdx        = '0;
    loFound      = 1'b0;
    loIdx        = '0;
    activeDone   = 1'b0;
    activeOneHot = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (stage_en_mask[i]) begin
        hiFound = 1'b1;
        hiIdx   = IDX_W'(i);
      end
      if (mask_q[i] && (IDX_W'(i) < activeStage_q)) begin
        loFound = 1'b1;
        loIdx   = IDX_W'(i);
      end
      if (activeStage_q == IDX_W'(i)) begin
        activeDone      = stage_done[i];
        activeOneHot[i] = 1'b1;
      end
    end
  end

  // UART idle timer. It counts only while the receiver is loading. It stops
  // at the timeout value instead of wrapping, so the load can still end
  // later if the UART address was still 0 when the timeout was reached.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      uartTimer_q <= '0;
    end else if (!uartQuiet || (state_q != S_UART_WAIT)) begin
      uartTimer_q <= '0;
    end else if (uartTimer_q != UT_LAST) begin
      uartTimer_q <= uartTimer_q + 1'b1;
    end
  end

  // Stage watchdog. It is zero on entry to S_STAGE_WAIT, counts each cycle
  // in that state and saturates at all-ones.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      wdTimer_q <= '0;
    end else if (state_q != S_STAGE_WAIT) begin
      wdTimer_q <= '0;
    end else if (wdTimer_q != WD_MAX) begin
      wdTimer_q <= wdTimer_q + 1'b1;
    end
  end

  // Ownership FSM. All status and control outputs are registered here. The
  // pulse outputs default to 0 every cycle, so each one lasts one cycle.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      mask_q        <= '0;
      activeStage_q <= '0;
      errStage_q    <= '0;
      uartInit_q    <= 1'b0;
      uartEnable_q  <= 1'b0;
      stageStart_q  <= '0;
      vgaEnable_q   <= 1'b1;
      seqError_q    <= 1'b0;
      seqDone_q     <= 1'b0;
    end else begin
      uartInit_q   <= 1'b0;
      uartEnable_q <= 1'b0;
      stageStart_q <= '0;
      seqDone_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!uart_rx_line || pb_start) begin
            uartInit_q  <= 1'b1;
            vgaEnable_q <= 1'b0;
            state_q     <= S_UART_EN;
          end
        end
        S_UART_EN: begin
          uartEnable_q <= 1'b1;
          state_q      <= S_UART_WAIT;
        end
        S_UART_WAIT: begin
          if (loadEnd) begin
            mask_q <= stage_en_mask;
            if (hiFound) begin
              activeStage_q <= hiIdx;
              state_q       <= S_STAGE_START;
            end else begin
              vgaEnable_q <= 1'b1;
              seqDone_q   <= 1'b1;
              state_q     <= S_IDLE;
            end
          end
        end
        S_STAGE_START: begin
          // stage_done is not sampled here, so a done level left over from
          // an earlier run cannot advance the sequence.
          stageStart_q <= activeOneHot;
          state_q      <= S_STAGE_WAIT;
        end
        S_STAGE_WAIT: begin
          // Done is checked before the watchdog. If both happen in the same
          // cycle, the stage counts as finished.
          if (activeDone) begin
            if (loFound) begin
              activeStage_q <= loIdx;
              state_q       <= S_STAGE_START;
            end else begin
              vgaEnable_q <= 1'b1;
              seqDone_q   <= 1'b1;
              state_q     <= S_IDLE;
            end
          end else if (wdExpired) begin
            seqError_q <= 1'b1;
            errStage_q <= activeStage_q;
            state_q    <= S_ERROR;
          end
        end
        S_ERROR: begin
          vgaEnable_q <= 1'b0;
          if (pb_start) begin
            seqError_q  <= 1'b0;
            vgaEnable_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          vgaEnable_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  // SRAM port mux. The select is the registered state, so the async reset
  // returns ownership to VGA at once and drops any write in progress.
  // Outside the UART and stage states, wdata follows the UART bus. It is
  // ignored there because we_n is held high.
  always_comb begin
    sram_addr  = vga_addr;
    sram_wdata = uart_wdata;
    sram_we_n  = 1'b1;
    case (state_q)
      S_UART_EN, S_UART_WAIT: begin
        sram_addr  = uart_addr;
        sram_wdata = uart_wdata;
        sram_we_n  = uart_we_n;
      end
      S_STAGE_START, S_STAGE_WAIT: begin
        for (int i = 0; i < NUM_STAGES; i++) begin
          if (activeStage_q == IDX_W'(i)) begin
            sram_addr  = stage_addr[i*ADDR_W +: ADDR_W];
            sram_wdata = stage_wdata[i*DATA_W +: DATA_W];
            sram_we_n  = stage_we_n[i];
          end
        end
      end
      default: begin
      end
    endcase
  end

  assign uart_init    = uartInit_q;
  assign uart_enable  = uartEnable_q;
  assign stage_start  = stageStart_q;
  assign vga_enable   = vgaEnable_q;
  assign seq_state    = state_q;
  assign active_stage = activeStage_q;
  assign err_stage    = errStage_q;
  assign seq_error    = seqError_q;
  assign seq_done     = seqDone_q;

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sram_stage_sequencer
//
// Self-checking bench for sram_stage_sequencer, with a short UART timeout and
// a 1000-cycle watchdog. The expected stage order comes from the mask: the
// enabled indices, highest first. Expected SRAM traffic comes from the bus
// values this bench drives.
// ---------------------------------------------------------------------------
module tb_sram_stage_sequencer;

  localparam int NS = 3;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int UT = 100;
  localparam int WD = 1000;
  localparam int IW = $clog2(NS) + 1;

  logic                 CLOCK_50_I = 1'b0;
  logic                 resetn = 1'b0;
  logic                 uart_rx_line = 1'b1;
  logic                 pb_start = 1'b0;
  logic [NS-1:0]        stage_en_mask = '0;
  logic                 uart_init;
  logic                 uart_enable;
  logic [AW-1:0]        uart_addr = '0;
  logic [DW-1:0]        uart_wdata = '0;
  logic                 uart_we_n = 1'b1;
  logic [NS-1:0]        stage_start;
  logic [NS-1:0]        stage_done = '0;
  logic [NS*AW-1:0]     stage_addr = '0;
  logic [NS*DW-1:0]     stage_wdata = '0;
  logic [NS-1:0]        stage_we_n = '1;
  logic [AW-1:0]        vga_addr = '0;
  logic                 vga_enable;
  logic [AW-1:0]        sram_addr;
  logic [DW-1:0]        sram_wdata;
  logic                 sram_we_n;
  logic [2:0]           seq_state;
  logic [IW-1:0]        active_stage;
  logic [IW-1:0]        err_stage;
  logic                 seq_error;
  logic                 seq_done;

  logic [AW-1:0]        bAddr [NS];
  logic [DW-1:0]        bData [NS];
  logic [NS-1:0]        bWe;

  int checks = 0;
  int errors = 0;

  sram_stage_sequencer #(
    .NUM_STAGES  (NS),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .UART_TIMEOUT(UT),
    .WD_CYCLES   (WD)
  ) dut (
    .CLOCK_50_I   (CLOCK_50_I),
    .resetn       (resetn),
    .uart_rx_line (uart_rx_line),
    .pb_start     (pb_start),
    .stage_en_mask(stage_en_mask),
    .uart_init    (uart_init),
    .uart_enable  (uart_enable),
    .uart_addr    (uart_addr),
    .uart_wdata   (uart_wdata),
    .uart_we_n    (uart_we_n),
    .stage_start  (stage_start),
    .stage_done   (stage_done),
    .stage_addr   (stage_addr),
    .stage_wdata  (stage_wdata),
    .stage_we_n   (stage_we_n),
    .vga_addr     (vga_addr),
    .vga_enable   (vga_enable),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_we_n    (sram_we_n),
    .seq_state    (seq_state),
    .active_stage (active_stage),
    .err_stage    (err_stage),
    .seq_error    (seq_error),
    .seq_done     (seq_done)
  );

  always #10 CLOCK_50_I = ~CLOCK_50_I;

  // Hard time limit so the run always ends, even if the design hangs.
  initial begin
    #5_000_000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLOCK_50_I);
  endtask

  // Waits a bounded number of cycles for a state code. Running out of
  // cycles counts as a failed check.
  task automatic waitState(input logic [2:0] code, input int limit);
    int n = 0;
    while (seq_state !== code && n < limit) begin
      tick();
      n++;
    end
    checkOutput("wait_state", 64'(seq_state), 64'(code));
  endtask

  // Randomises every stage bus and drives done noise on the other stages.
  // Also drives random start requests, which must be ignored mid-run.
  task automatic applyStimulus(input int active, input bit directed);
    for (int i = 0; i < NS; i++) begin
      bAddr[i] = AW'($urandom);
      bData[i] = DW'($urandom);
      bWe[i]   = 1'($urandom);
    end
    if (directed) begin
      bAddr[active] = 18'h01234;
      bData[active] = 16'hBEEF;
      bWe[active]   = 1'b0;
    end
    for (int i = 0; i < NS; i++) begin
      stage_addr[i*AW +: AW]  = bAddr[i];
      stage_wdata[i*DW +: DW] = bData[i];
    end
    stage_we_n   = bWe;
    stage_done   = NS'($urandom) & ~(NS'(1) << active);
    pb_start     = 1'($urandom);
    uart_rx_line = 1'($urandom);
    vga_addr     = AW'($urandom);
  endtask

  task automatic startLoad(input bit useRx);
    if (useRx) uart_rx_line = 1'b0;
    else       pb_start = 1'b1;
    tick();
    uart_rx_line = 1'b1;
    pb_start     = 1'b0;
    checkOutput("uart_init_pulse", 64'(uart_init), 64'd1);
    checkOutput("uart_enable_early", 64'(uart_enable), 64'd0);
    checkOutput("vga_off_load", 64'(vga_enable), 64'd0);
    tick();
    checkOutput("uart_init_once", 64'(uart_init), 64'd0);
    checkOutput("uart_enable_pulse", 64'(uart_enable), 64'd1);
    checkOutput("state_uart_wait", 64'(seq_state), 64'd2);
  endtask

  // nWrites writes go to addresses 0..nWrites-1, then the UART goes idle.
  // With holdZero the address drops to 0 while idle: the load must not end
  // until the address moves off 0.
  task automatic uartLoad(input int nWrites, input logic [NS-1:0] mask, input bit holdZero);
    logic [DW-1:0] d;
    stage_en_mask = mask;
    for (int k = 0; k < nWrites; k++) begin
      d          = DW'($urandom);
      uart_we_n  = 1'b0;
      uart_addr  = AW'(k);
      uart_wdata = d;
      #1;
      checkOutput("uart_mux_addr", 64'(sram_addr), 64'(k));
      checkOutput("uart_mux_data", 64'(sram_wdata), 64'(d));
      checkOutput("uart_mux_we", 64'(sram_we_n), 64'd0);
      tick();
    end
    uart_we_n = 1'b1;
    if (holdZero) begin
      uart_addr = '0;
      repeat (UT + 20) tick();
      checkOutput("load_addr0_hold", 64'(seq_state), 64'd2);
      uart_addr = AW'(5);
      tick();
    end else begin
      repeat (UT - 1) tick();
      checkOutput("load_timeout_hold", 64'(seq_state), 64'd2);
      tick();
    end
    checkOutput("load_end_state", 64'(seq_state), (mask != '0) ? 64'd3 : 64'd0);
    stage_en_mask = NS'($urandom);
  endtask

  // Runs the enabled stages, which must start highest index first.
  // directedIdx names the stage whose first busy cycle gets the fixed
  // 0x1234/0xBEEF write (-1 for none).
  task automatic runStages(input logic [NS-1:0] mask, input int directedIdx);
    int expQ[$];
    int idx;
    int n;
    for (int i = NS - 1; i >= 0; i--) if (mask[i]) expQ.push_back(i);
    if (expQ.size() == 0) begin
      checkOutput("empty_done_pulse", 64'(seq_done), 64'd1);
      checkOutput("empty_vga_on", 64'(vga_enable), 64'd1);
      tick();
      checkOutput("empty_done_once", 64'(seq_done), 64'd0);
      return;
    end
    while (expQ.size() != 0) begin
      idx = expQ.pop_front();
      n = 0;
      while (stage_start == '0 && n < 4) begin
        tick();
        n++;
      end
      checkOutput("start_vec", 64'(stage_start), 64'(1) << idx);
      checkOutput("active_stage", 64'(active_stage), 64'(idx));
      checkOutput("vga_off_stage", 64'(vga_enable), 64'd0);
      tick();
      checkOutput("start_once", 64'(stage_start), 64'd0);
      for (int c = 0; c < int'($urandom_range(1, 4)); c++) begin
        applyStimulus(idx, (c == 0) && (idx == directedIdx));
        #1;
        checkOutput("stage_mux_addr", 64'(sram_addr), 64'(bAddr[idx]));
        checkOutput("stage_mux_data", 64'(sram_wdata), 64'(bData[idx]));
        checkOutput("stage_mux_we", 64'(sram_we_n), 64'(bWe[idx]));
        tick();
        checkOutput("stage_ignore_noise", 64'(seq_state), 64'd4);
      end
      pb_start     = 1'b0;
      uart_rx_line = 1'b1;
      stage_we_n   = '1;
      stage_done   = NS'(1) << idx;
      tick();
      stage_done = '0;
      if (expQ.size() != 0) begin
        checkOutput("advance_state", 64'(seq_state), 64'd3);
      end else begin
        checkOutput("run_end_state", 64'(seq_state), 64'd0);
        checkOutput("run_done_pulse", 64'(seq_done), 64'd1);
        checkOutput("run_vga_on", 64'(vga_enable), 64'd1);
        tick();
        checkOutput("run_done_once", 64'(seq_done), 64'd0);
      end
    end
  endtask

  initial begin
    logic [NS-1:0] m;

    // Reset values
    repeat (2) tick();
    checkOutput("rst_state", 64'(seq_state), 64'd0);
    checkOutput("rst_vga", 64'(vga_enable), 64'd1);
    checkOutput("rst_start", 64'(stage_start), 64'd0);
    checkOutput("rst_uart_init", 64'(uart_init), 64'd0);
    checkOutput("rst_error", 64'(seq_error), 64'd0);
    checkOutput("rst_err_stage", 64'(err_stage), 64'd0);
    checkOutput("rst_active", 64'(active_stage), 64'd0);
    checkOutput("rst_done", 64'(seq_done), 64'd0);
    resetn = 1'b1;
    tick();

    // All three stages, including the fixed write from stage 2
    $display("[TB] full run, mask 111");
    startLoad(1'b0);
    uartLoad(4, 3'b111, 1'b0);
    runStages(3'b111, 2);

    // Single stage, then no stages
    $display("[TB] mask 010 and mask 000");
    startLoad(1'b0);
    uartLoad(4, 3'b010, 1'b0);
    runStages(3'b010, -1);
    startLoad(1'b1);
    uartLoad(3, 3'b000, 1'b0);
    runStages(3'b000, -1);

    // The load may not end while the UART address is still 0
    $display("[TB] address-zero hold");
    startLoad(1'b1);
    uartLoad(2, 3'b101, 1'b1);
    runStages(3'b101, -1);

    // Random masks and start sources
    $display("[TB] random runs");
    for (int r = 0; r < 6; r++) begin
      m = NS'($urandom_range(0, 7));
      startLoad(1'($urandom));
      uartLoad(int'($urandom_range(2, 5)), m, 1'b0);
      runStages(m, -1);
    end

    // Watchdog expiry on stage 1
    $display("[TB] watchdog expiry");
    startLoad(1'b0);
    uartLoad(4, 3'b010, 1'b0);
    waitState(3'd4, 4);
    repeat (WD - 1) tick();
    checkOutput("wd_hold", 64'(seq_state), 64'd4);
    tick();
    checkOutput("wd_error_state", 64'(seq_state), 64'd5);
    checkOutput("wd_seq_error", 64'(seq_error), 64'd1);
    checkOutput("wd_err_stage", 64'(err_stage), 64'd1);
    checkOutput("wd_vga_off", 64'(vga_enable), 64'd0);
    stage_we_n = '0;
    vga_addr   = AW'($urandom);
    #1;
    checkOutput("err_sram_we", 64'(sram_we_n), 64'd1);
    checkOutput("err_sram_addr", 64'(sram_addr), 64'(vga_addr));
    stage_we_n   = '1;
    uart_rx_line = 1'b0;
    tick();
    uart_rx_line = 1'b1;
    checkOutput("err_ignore_rx", 64'(seq_state), 64'd5);
    pb_start = 1'b1;
    tick();
    pb_start = 1'b0;
    checkOutput("err_clear_state", 64'(seq_state), 64'd0);
    checkOutput("err_clear_flag", 64'(seq_error), 64'd0);
    checkOutput("err_clear_vga", 64'(vga_enable), 64'd1);

    // Done arrives in the same cycle as expiry: done must win
    $display("[TB] done on the expiry cycle");
    startLoad(1'b0);
    uartLoad(3, 3'b010, 1'b0);
    waitState(3'd4, 4);
    repeat (WD - 1) tick();
    stage_done = 3'b010;
    tick();
    stage_done = '0;
    checkOutput("race_state", 64'(seq_state), 64'd0);
    checkOutput("race_no_error", 64'(seq_error), 64'd0);
    checkOutput("race_done_pulse", 64'(seq_done), 64'd1);
    checkOutput("race_vga_on", 64'(vga_enable), 64'd1);

    // Asynchronous reset while stage 2 is writing
    $display("[TB] reset mid-stage");
    startLoad(1'b0);
    uartLoad(2, 3'b100, 1'b0);
    waitState(3'd4, 4);
    stage_we_n = 3'b011;
    #1;
    checkOutput("pre_rst_we", 64'(sram_we_n), 64'd0);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("mid_rst_state", 64'(seq_state), 64'd0);
    checkOutput("mid_rst_we", 64'(sram_we_n), 64'd1);
    checkOutput("mid_rst_vga", 64'(vga_enable), 64'd1);
    checkOutput("mid_rst_start", 64'(stage_start), 64'd0);
    checkOutput("mid_rst_active", 64'(active_stage), 64'd0);
    tick();
    stage_we_n = '1;
    resetn = 1'b1;
    tick();
    checkOutput("post_rst_state", 64'(seq_state), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
